// File: rtl/video_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : video_scan_controller
// Purpose  : Raster scan timing generator. Walks a horizontal/vertical counter
//            pair over the full frame (active + porches + sync), requests one
//            pixel from upstream per active position, and presents registered
//            pixel, data enable, active-low syncs and a frame-start pulse to
//            the display, all one clock after the counter position.
// Ports    : Clock       - pixel clock (rising edge)
//            Reset       - asynchronous active-low reset
//            Enable      - request to scan frames
//            video       - upstream {R,G,B} pixel, valid when VideoReady=1
//            VideoReady  - pixel request to upstream (combinational)
//            pixel_out   - registered pixel to display
//            de_out      - registered data enable
//            hsync_out   - registered horizontal sync, active low
//            vsync_out   - registered vertical sync, active low
//            frame_start - one-cycle pulse with first output pixel of a frame
// Revision : 1.0 - initial release
// ============================================================================
module video_scan_controller #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [23:0] video,
  output logic        VideoReady,
  output logic [23:0] pixel_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
  localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);

  // Region bounds are compared one bit wider than the counters so a sync
  // pulse ending exactly at the total (zero back porch) does not wrap to 0.
  localparam logic [c_hw:0] c_h_act   = (c_hw+1)'(H_ACTIVE);
  localparam logic [c_hw:0] c_hs_beg  = (c_hw+1)'(H_ACTIVE + H_FP);
  localparam logic [c_hw:0] c_hs_end  = (c_hw+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_vw:0] c_v_act   = (c_vw+1)'(V_ACTIVE);
  localparam logic [c_vw:0] c_vs_beg  = (c_vw+1)'(V_ACTIVE + V_FP);
  localparam logic [c_vw:0] c_vs_end  = (c_vw+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [c_hw-1:0] r_h_count;
  logic [c_hw-1:0] w_h_next;
  logic [c_vw-1:0] r_v_count;
  logic [c_vw-1:0] w_v_next;

  logic [c_hw:0]   w_h_ext;
  logic [c_vw:0]   w_v_ext;
  logic            w_run;
  logic            w_h_wrap;
  logic            w_v_wrap;
  logic            w_ready;
  logic            w_hsync_on;
  logic            w_vsync_on;
  logic            w_first_pos;

  logic [23:0]     r_pixel;
  logic            r_de;
  logic            r_hsync_n;
  logic            r_vsync_n;
  logic            r_frame_start;

  assign w_h_ext     = {1'b0, r_h_count};
  assign w_v_ext     = {1'b0, r_v_count};
  assign w_run       = (r_state == ST_RUN);
  assign w_h_wrap    = (r_h_count == c_h_last);
  assign w_v_wrap    = (r_v_count == c_v_last);
  assign w_ready     = w_run && (w_h_ext < c_h_act) && (w_v_ext < c_v_act);
  assign w_hsync_on  = w_run && (w_h_ext >= c_hs_beg) && (w_h_ext < c_hs_end);
  assign w_vsync_on  = w_run && (w_v_ext >= c_vs_beg) && (w_v_ext < c_vs_end);
  assign w_first_pos = w_run && (r_h_count == '0) && (r_v_count == '0);

  // State register and scan counters
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_h_count <= '0;
      r_v_count <= '0;
    end else begin
      r_state   <= w_state_next;
      r_h_count <= w_h_next;
      r_v_count <= w_v_next;
    end
  end

  // Next-state and counter advance. Enable is only honoured at the last
  // frame position so a frame is never cut short.
  always_comb begin
    w_state_next = r_state;
    w_h_next     = r_h_count;
    w_v_next     = r_v_count;
    case (r_state)
      ST_IDLE: begin
        w_h_next = '0;
        w_v_next = '0;
        if (Enable) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_h_wrap) begin
          w_h_next = '0;
          if (w_v_wrap) begin
            w_v_next = '0;
            if (!Enable) begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_v_next = r_v_count + 1'b1;
          end
        end else begin
          w_h_next = r_h_count + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_h_next     = '0;
        w_v_next     = '0;
      end
    endcase
  end

  // Output pipeline: every display output is one clock behind its position.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pixel       <= 24'h000000;
      r_de          <= 1'b0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel       <= w_ready ? video : 24'h000000;
      r_de          <= w_ready;
      r_hsync_n     <= ~w_hsync_on;
      r_vsync_n     <= ~w_vsync_on;
      r_frame_start <= w_first_pos;
    end
  end

  assign VideoReady  = w_ready;
  assign pixel_out   = r_pixel;
  assign de_out      = r_de;
  assign hsync_out   = r_hsync_n;
  assign vsync_out   = r_vsync_n;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_scan_controller
// Purpose  : Self-checking bench for video_scan_controller using small frame
//            parameters (8 clocks per line, 6 lines per frame). A frame-level
//            reference model tracks the scan as a single linear position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_scan_controller;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [23:0] video;
  logic        VideoReady;
  logic [23:0] pixel_out;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;

  video_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .video      (video),
    .VideoReady (VideoReady),
    .pixel_out  (pixel_out),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_start(frame_start)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: scanning flag plus linear frame position.
  bit          m_run;
  int          m_pos;
  int          n_req;
  logic [23:0] e_pix;
  bit          e_de;
  bit          e_hs;
  bit          e_vs;
  bit          e_fs;

  function automatic bit f_vr(bit run, int pos);
    return run && ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    e_pix = 24'h0;
    e_de  = 1'b0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_fs  = 1'b0;
  endtask

  task automatic check_all();
    chk("VideoReady",  {31'b0, VideoReady},  {31'b0, f_vr(m_run, m_pos)});
    chk("pixel_out",   {8'b0, pixel_out},    {8'b0, e_pix});
    chk("de_out",      {31'b0, de_out},      {31'b0, e_de});
    chk("hsync_out",   {31'b0, hsync_out},   {31'b0, e_hs});
    chk("vsync_out",   {31'b0, vsync_out},   {31'b0, e_vs});
    chk("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
  endtask

  // One clock: update the model at the rising edge, check at the falling edge.
  task automatic cycle();
    int h;
    int v;
    bit vr;
    @(posedge Clock);
    if (!Reset) begin
      model_reset();
    end else begin
      h  = m_pos % HT;
      v  = m_pos / HT;
      vr = f_vr(m_run, m_pos);
      e_pix = vr ? video : 24'h0;
      e_de  = vr;
      e_hs  = !(m_run && h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(m_run && v >= VA + VF && v < VA + VF + VS);
      e_fs  = m_run && (m_pos == 0);
      if (vr) n_req++;
      if (!m_run) begin
        if (Enable) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else begin
        if (m_pos == FT - 1 && !Enable) m_run = 1'b0;
        m_pos = (m_pos + 1) % FT;
      end
    end
    @(negedge Clock);
    check_all();
  endtask

  task automatic wait_pos(int target);
    int k;
    k = 0;
    while (!(m_run && m_pos == target) && k < 200) begin
      video = 24'($urandom);
      cycle();
      k++;
    end
    chk("wait_pos", {31'b0, (m_run && m_pos == target)}, 32'd1);
  endtask

  initial begin
    int cnt;
    Reset  = 1'b1;
    Enable = 1'b1;
    video  = 24'h0;
    n_req  = 0;
    model_reset();
    #2 Reset = 1'b0;

    // Held in reset with Enable high: outputs stay at reset values
    repeat (3) cycle();

    // Release with Enable=1; two frames with video = running request count
    Reset = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int i = 0; i < FT; i++) begin
        video = 24'(n_req);
        cycle();
        cnt += int'(VideoReady);
      end
      chk("frame_requests", cnt, HA * VA);
    end

    // Drop Enable at frame cycle 10: frame still completes
    cnt = 0;
    for (int i = 0; i < FT; i++) begin
      if (i == 10) Enable = 1'b0;
      video = 24'($urandom);
      cycle();
      cnt += int'(VideoReady);
    end
    chk("frame_requests_drop", cnt, HA * VA);

    // Idle afterwards: no requests
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      video = 24'($urandom);
      cycle();
      cnt += int'(VideoReady);
    end
    chk("idle_requests", cnt, 0);

    // Restart, then assert reset asynchronously at frame cycle 20
    Enable = 1'b1;
    wait_pos(20);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) cycle();

    // Release with Enable low: stays idle
    Reset  = 1'b1;
    Enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      cnt += int'(VideoReady);
    end
    chk("post_reset_idle", cnt, 0);

    // Random Enable and pixel data against the model
    for (int i = 0; i < 400; i++) begin
      Enable = ($urandom_range(0, 3) != 0);
      video  = 24'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/video_scan_controller.md
VIDEO_SCAN_CONTROLLER -- requirements
Module: video_scan_controller

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, meaning horizontal front-porch clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning horizontal sync-pulse clocks.
REQ-004 The block SHALL have parameter H_BP, default 88, meaning horizontal back-porch clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 600, meaning active lines per frame.
REQ-006 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 1, 4 and 23, meaning vertical front porch, sync and back porch in lines.
REQ-007 Port Clock, input, 1 bit: single pixel clock; all logic is on its rising edge.
REQ-008 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port Enable, input, 1 bit: request to run frame scanning.
REQ-010 Port video, input, 24 bits: upstream pixel {R,G,B}, valid in every cycle that VideoReady is high.
REQ-011 Port VideoReady, output, 1 bit: pixel request to upstream; one pixel is consumed per high cycle.
REQ-012 Port pixel_out, output, 24 bits: registered pixel to the display.
REQ-013 Port de_out, output, 1 bit: registered data enable, aligned with pixel_out.
REQ-014 Port hsync_out and vsync_out, output, 1 bit each: registered, active-low syncs, aligned with pixel_out.
REQ-015 Port frame_start, output, 1 bit: one-cycle pulse aligned with the first output pixel of each frame.

Function
REQ-016 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal the corresponding vertical sum.
REQ-017 Counters SHALL be h_count (0..H_TOTAL-1) and v_count (0..V_TOTAL-1), each sized to clog2 of its total.
REQ-018 The state machine SHALL have exactly two states, IDLE and RUN.
REQ-019 In IDLE, both counters SHALL hold at 0 and VideoReady SHALL be 0.
REQ-020 IDLE SHALL move to RUN on the first cycle with Enable=1; the first RUN cycle has h_count=0 and v_count=0.
REQ-021 In RUN, h_count SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-022 In RUN, v_count SHALL increment on each h_count wrap and wrap from V_TOTAL-1 to 0.
REQ-023 RUN SHALL move to IDLE only at the last frame position (h_count=H_TOTAL-1, v_count=V_TOTAL-1) with Enable=0; Enable falling mid-frame SHALL NOT truncate the frame.
REQ-024 If Enable=1 at the last frame position, the block SHALL stay in RUN and start the next frame with no gap.
REQ-025 VideoReady SHALL be a combinational decode of registered state: RUN and h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-026 When VideoReady=1, pixel_out SHALL load video at the next edge; otherwise it SHALL load 24'h000000.
REQ-027 de_out SHALL equal VideoReady delayed by one cycle.
REQ-028 hsync_out SHALL be 0 one cycle after any RUN cycle with H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, and 1 otherwise.
REQ-029 vsync_out SHALL be 0 one cycle after any RUN cycle with V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, and 1 otherwise.
REQ-030 frame_start SHALL be 1 one cycle after any RUN cycle with h_count=0 and v_count=0, and 0 otherwise.
REQ-031 Total latency from a counter position to its outputs SHALL be exactly 1 clock, identical for all outputs.
REQ-032 Exactly H_ACTIVE×V_ACTIVE VideoReady cycles SHALL occur per frame (480000 at defaults).

Reset
REQ-033 On Reset=0, the block SHALL asynchronously go to IDLE with h_count=0 and v_count=0.
REQ-034 During reset, pixel_out SHALL be 0, de_out 0, hsync_out 1, vsync_out 1, frame_start 0, and VideoReady 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; after release, scanning restarts from (0,0) only via Enable.
REQ-036 Reset release SHALL be synchronized externally; the block needs no internal synchronizer.

Verification (small parameters: H 4/1/2/1 giving H_TOTAL=8; V 3/1/1/1 giving V_TOTAL=6)
REQ-037 Release reset with Enable=1 -> VideoReady is high for 4 of every 8 cycles on lines 0-2, 12 high cycles per 48-cycle frame, first frame_start 1 cycle after the RUN entry.
REQ-038 Drive video=count of VideoReady cycles -> pixel_out shows 0,1,2,3 with de_out=1, then 0 with de_out=0, one cycle after each request.
REQ-039 Check syncs -> hsync_out is low at output cycles 6-7 of each line; vsync_out is low for all 8 cycles of line 4.
REQ-040 Drop Enable at frame cycle 10 -> the frame completes all 48 cycles, then the block goes to IDLE and no further VideoReady occurs; raising Enable restarts at (0,0).
REQ-041 Assert Reset at frame cycle 20 -> all outputs take their reset values within the same cycle, with no clock edge needed.
REQ-042 Default parameters with the upstream two-colour band source -> 480000 requests per frame; the colour changes every 80 pixels, giving 10 bands per 800-pixel line.
